// File: rtl/shift_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROL/ROR) with carry/zero/error flags,
// binary-weighted stages grouped between register slots, and ripple-ready valid/ready flow control.
module shift_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_err,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int NSTAGE = $clog2(WIDTH);
    localparam int LAT    = (NSTAGE + REG_EVERY - 1) / REG_EVERY;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // Slot state: one entry per register slot, slot LAT-1 drives the outputs.
    logic [LAT-1:0]    r_valid;
    logic [LAT-1:0]    r_carry;
    logic [LAT-1:0]    r_err;
    logic [WIDTH-1:0]  r_data  [LAT];
    logic [NSTAGE-1:0] r_shamt [LAT];
    logic [2:0]        r_op    [LAT];
    logic [TAG_W-1:0]  r_tag   [LAT];
    logic              r_zero;

    // Group sources: what feeds the first stage of each group of REG_EVERY stages.
    logic [LAT-1:0]    w_g_valid;
    logic [LAT-1:0]    w_g_carry;
    logic [LAT-1:0]    w_g_err;
    logic [WIDTH-1:0]  w_g_data  [LAT];
    logic [NSTAGE-1:0] w_g_shamt [LAT];
    logic [2:0]        w_g_op    [LAT];
    logic [TAG_W-1:0]  w_g_tag   [LAT];

    // Slot inputs: result of the last stage of each group.
    logic [WIDTH-1:0]  w_s_data [LAT];
    logic [LAT-1:0]    w_s_carry;
    logic [LAT-1:0]    w_load;
    logic              w_last_zero;

    for (genvar g = 0; g < LAT; g++) begin : g_src
        if (g == 0) begin : g_in
            assign w_g_valid[g] = in_valid;
            assign w_g_carry[g] = 1'b0;
            assign w_g_err[g]   = (in_op > OP_ROR);
            assign w_g_data[g]  = in_data;
            assign w_g_shamt[g] = in_shamt;
            assign w_g_op[g]    = in_op;
            assign w_g_tag[g]   = in_tag;
        end else begin : g_slot
            assign w_g_valid[g] = r_valid[g-1];
            assign w_g_carry[g] = r_carry[g-1];
            assign w_g_err[g]   = r_err[g-1];
            assign w_g_data[g]  = r_data[g-1];
            assign w_g_shamt[g] = r_shamt[g-1];
            assign w_g_op[g]    = r_op[g-1];
            assign w_g_tag[g]   = r_tag[g-1];
        end
        // A slot can load if it or any slot downstream of it has room this cycle.
        assign w_load[g] = out_ready | ~(&r_valid[LAT-1:g]);
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int G   = k / REG_EVERY;
        localparam int AMT = 1 << k;

        logic [WIDTH-1:0] w_di;
        logic [WIDTH-1:0] w_do;
        logic             w_ci;
        logic             w_co;
        logic             w_act;

        if (k % REG_EVERY == 0) begin : g_head
            assign w_di = w_g_data[G];
            assign w_ci = w_g_carry[G];
        end else begin : g_chain
            assign w_di = g_stage[k-1].w_do;
            assign w_ci = g_stage[k-1].w_co;
        end

        assign w_act = w_g_shamt[G][k] & ~w_g_err[G];

        // Carry is the last bit pushed out by the most recent active stage.
        always_comb begin
            // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
            w_do = w_di;
            w_co = w_ci;
            if (w_act) begin
                case (w_g_op[G])
                    OP_SLL: begin
                        w_do = w_di << AMT;
                        w_co = w_di[WIDTH-AMT];
                    end
                    OP_SRL: begin
                        w_do = w_di >> AMT;
                        w_co = w_di[AMT-1];
                    end
                    OP_SRA: begin
                        w_do = $unsigned($signed(w_di) >>> AMT);
                        w_co = w_di[AMT-1];
                    end
                    OP_ROL: begin
                        w_do = (w_di << AMT) | (w_di >> (WIDTH - AMT));
                        w_co = w_di[WIDTH-AMT];
                    end
                    OP_ROR: begin
                        w_do = (w_di >> AMT) | (w_di << (WIDTH - AMT));
                        w_co = w_di[AMT-1];
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < LAT; g++) begin : g_tap
        localparam int LASTK = (((g + 1) * REG_EVERY < NSTAGE) ? (g + 1) * REG_EVERY : NSTAGE) - 1;
        assign w_s_data[g]  = g_stage[LASTK].w_do;
        assign w_s_carry[g] = g_stage[LASTK].w_co;
    end

    assign w_last_zero = (w_s_data[LAT-1] == '0);

    always_ff @(posedge clk) begin
        // NOTE: every slot field is reset, not just valid, because the outputs must read 0 after reset.
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            r_err   <= '0;
            r_zero  <= 1'b0;
            for (int g = 0; g < LAT; g++) begin
                r_data[g]  <= '0;
                r_shamt[g] <= '0;
                r_op[g]    <= '0;
                r_tag[g]   <= '0;
            end
        end else begin
            for (int g = 0; g < LAT; g++) begin
                if (w_load[g]) begin
                    // NOTE: non-blocking so each slot captures its upstream neighbour's pre-edge value.
                    r_valid[g] <= w_g_valid[g];
                    if (w_g_valid[g]) begin
                        r_data[g]  <= w_s_data[g];
                        r_carry[g] <= w_s_carry[g];
                        r_err[g]   <= w_g_err[g];
                        r_shamt[g] <= w_g_shamt[g];
                        r_op[g]    <= w_g_op[g];
                        r_tag[g]   <= w_g_tag[g];
                    end
                end
            end
            if (w_load[LAT-1] && w_g_valid[LAT-1]) begin
                r_zero <= w_last_zero;
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[LAT-1];
    assign out_data  = r_data[LAT-1];
    assign out_carry = r_carry[LAT-1];
    assign out_zero  = r_zero;
    assign out_err   = r_err[LAT-1];
    assign out_tag   = r_tag[LAT-1];

endmodule
